// File: rtl/num_to_7sd_if.sv
// Front-panel number bus: value/format in,
// display image and coin breakdown out.
interface num_to_7sd_if;
  logic [13:0] int_num;
  logic        decimal;
  logic [31:0] seven_seg;
  logic [13:0] coins;

  modport master (
    output int_num,
    output decimal,
    input  seven_seg,
    input  coins
  );

  modport slave (
    input  int_num,
    input  decimal,
    output seven_seg,
    output coins
  );
endinterface

// File: rtl/num_to_7sd.sv
// Cent amount -> 4-digit 7-seg image + coin count.
// LEAD_ZERO_BLANK_EN blanks a zero dollar-tens digit.
module num_to_7sd (
  input  logic         clk,
  input  logic         rst,
  num_to_7sd_if.slave  bus
);

  logic [15:0] bcd;
  logic [3:0]  thou, hund, tens, unit;
  logic        ovf;
  logic [6:0]  rem;
  logic [6:0]  r25;
  logic [6:0]  r10;
  logic [1:0]  qtr;
  logic [1:0]  dim;
  logic        nck;
  logic [31:0] seg_d, seg_q;
  logic [13:0] coins_d, coins_q;

  function automatic logic [7:0] seg7(
    input logic [3:0] d
  );
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Double-dabble; digits above 9999 fall off
  // but are masked by the overflow dashes.
  always_comb begin
    bcd = '0;
    for (int i = 13; i >= 0; i--) begin
      for (int k = 0; k < 4; k++) begin
        if (bcd[4*k +: 4] >= 4'd5)
          bcd[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
      bcd = {bcd[14:0], bus.int_num[i]};
    end
  end

  assign thou = bcd[15:12];
  assign hund = bcd[11:8];
  assign tens = bcd[7:4];
  assign unit = bcd[3:0];
  assign ovf  = bus.int_num > 14'd9999;

  always_comb begin
    seg_d = {seg7(thou), seg7(hund),
             seg7(tens), seg7(unit)};
    if (bus.decimal) begin
      seg_d[31] = seg_d[31];
      seg_d[23] = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
      if (thou == 4'd0)
        seg_d[31:24] = 8'hFF;
`endif
    end
    if (ovf)
      seg_d = 32'hBFBF_BFBF;
  end

  // Below 1000 the dollar count is the
  // hundreds digit; cents come from tens/units.
  always_comb begin
    rem = {3'd0, tens} * 7'd10 + {3'd0, unit};
    if (rem >= 7'd75) begin
      qtr = 2'd3; r25 = rem - 7'd75;
    end else if (rem >= 7'd50) begin
      qtr = 2'd2; r25 = rem - 7'd50;
    end else if (rem >= 7'd25) begin
      qtr = 2'd1; r25 = rem - 7'd25;
    end else begin
      qtr = 2'd0; r25 = rem;
    end
    if (r25 >= 7'd20) begin
      dim = 2'd2; r10 = r25 - 7'd20;
    end else if (r25 >= 7'd10) begin
      dim = 2'd1; r10 = r25 - 7'd10;
    end else begin
      dim = 2'd0; r10 = r25;
    end
    nck = r10 >= 7'd5;
    if (bus.int_num >= 14'd1000)
      coins_d = 14'd9999;
    else
      coins_d = {10'd0, hund} * 14'd1000
              + {12'd0, qtr}  * 14'd100
              + {12'd0, dim}  * 14'd10
              + {13'd0, nck};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q   <= 32'hFFFF_FFFF;
      coins_q <= '0;
    end else begin
      seg_q   <= seg_d;
      coins_q <= coins_d;
    end
  end

  assign bus.seven_seg = seg_q;
  assign bus.coins     = coins_q;

endmodule

// File: tb/tb_num_to_7sd.sv
// Scoreboard bench for num_to_7sd:
// expectations queued at drive, popped after edge.
module tb_num_to_7sd;

  typedef struct {
    string       tag;
    logic [31:0] seg;
    logic [13:0] coins;
  } exp_t;

`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [7:0] D3Z = 8'hFF;
`else
  localparam logic [7:0] D3Z = 8'hC0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;
  exp_t q[$];

  num_to_7sd_if bus ();

  num_to_7sd dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [7:0] cd(input int d);
    logic [7:0] t [10] = '{8'hC0, 8'hF9, 8'hA4,
      8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90};
    return t[d];
  endfunction

  function automatic exp_t model(
    input int n, input bit dec
  );
    exp_t e;
    int th, r;
    e.tag = $sformatf("n%0d_d%0d", n, dec);
    if (n > 9999) begin
      e.seg = 32'hBFBFBFBF;
    end else begin
      th = n / 1000;
      e.seg = {cd(th), cd(n / 100 % 10),
               cd(n / 10 % 10), cd(n % 10)};
      if (dec) begin
        e.seg[23] = 1'b0;
        if (th == 0) e.seg[31:24] = D3Z;
      end
    end
    if (n >= 1000) begin
      e.coins = 14'd9999;
    end else begin
      r = n % 100;
      e.coins = 14'((n / 100) * 1000
              + (r / 25) * 100
              + ((r % 25) / 10) * 10
              + ((r % 25) % 10) / 5);
    end
    return e;
  endfunction

  task automatic drive(
    input int n, input bit dec, input bit r
  );
    exp_t e;
    @(negedge clk);
    rst = r;
    bus.int_num = n[13:0];
    bus.decimal = dec;
    if (r) begin
      e.tag = "reset";
      e.seg = 32'hFFFFFFFF;
      e.coins = '0;
    end else begin
      e = model(n, dec);
    end
    q.push_back(e);
  endtask

  task automatic drive_lit(
    input int n, input bit dec,
    input logic [31:0] s, input int c
  );
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    bus.int_num = n[13:0];
    bus.decimal = dec;
    e.tag = $sformatf("lit%0d", n);
    e.seg = s;
    e.coins = 14'(c);
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, "_seg"}, bus.seven_seg, e.seg);
      chk({e.tag, "_coins"},
          {18'd0, bus.coins}, {18'd0, e.coins});
    end
  end

  initial begin
    bus.int_num = '0;
    bus.decimal = 1'b0;
    drive(4321, 1, 1);
    drive(4321, 1, 1);
    drive_lit(125, 1, {D3Z, 24'h79A492}, 1100);
    drive_lit(0, 1, {D3Z, 24'h40C0C0}, 0);
    drive_lit(390, 0, 32'hC0B090C0, 3311);
    drive(7, 0, 0);
    drive_lit(12000, 1, 32'hBFBFBFBF, 9999);
    drive_lit(500, 1, {D3Z, 24'h12C0C0}, 5000);
    drive_lit(25, 1, {D3Z, 24'h40A492}, 100);
    drive_lit(3311, 0, 32'hB0B0F9F9, 9999);
    drive(9999, 1, 0);
    drive(10000, 0, 0);
    drive(16383, 1, 0);
    drive(999, 1, 0);
    drive(1000, 1, 0);
    drive(994, 0, 0);
    drive(1234, 1, 0);
    drive(77, 1, 0);
    drive(5555, 1, 1);
    drive(88, 0, 0);
    for (int i = 0; i < 60; i++)
      drive(int'($urandom_range(0, 16383)),
            bit'($urandom_range(0, 1)), 0);
    for (int i = 0; i < 30; i++)
      drive(int'($urandom_range(0, 999)),
            bit'($urandom_range(0, 1)), 0);
    repeat (4) @(posedge clk);
    #2;
    if (q.size() != 0)
      chk("drain", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
